// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end.
// Holds the fetch PC and issues one outstanding request at a time to
// instruction memory. Returned words go into a 2-entry queue whose head feeds
// the IF/ID register. A redirect flushes the queue and discards any response
// still in flight.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   redirect            taken branch/jump this cycle
//   redirect_pc         redirect target (bits [1:0] ignored)
//   pc                  next address to request
//   imem_req/imem_addr  request valid / word-aligned address
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   response valid / instruction word
//   id_valid            queue head valid
//   id_pc/id_instr      PC and instruction of queue head
//   id_ready            decode accepts the head this cycle
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   input  logic        id_ready
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   state_t           state;
   state_t           state_n;
   logic [XLEN-1:0]  pc_n;
   logic [XLEN-1:0]  req_pc;
   logic [XLEN-1:0]  req_pc_n;
   logic             drop;
   logic             drop_n;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_n;
   logic [CNT_W-1:0] occ_next;
   logic             push;
   logic             pop;
   entry_t           head;
   entry_t           tail;
   entry_t           resp;

   // pc is always word aligned, so the address is just the register
   assign imem_addr = pc & ~XLEN'(3);
   assign id_pc     = head.pc;
   assign id_instr  = head.instr;

   // Queue traffic; a redirect suppresses the push of a coincident response
   assign push     = (state == WAIT) && imem_rvalid && !drop && !redirect;
   assign pop      = id_valid && id_ready;
   assign occ_next = count + CNT_W'(push) - CNT_W'(pop);
   assign count_n  = redirect ? '0 : occ_next;
   assign resp     = '{pc: req_pc, instr: imem_rdata};

   // Next-state and next-PC logic; redirect overrides everything else
   always_comb begin
      state_n  = state;
      pc_n     = pc;
      req_pc_n = req_pc;
      drop_n   = drop;

      case (state)
         IDLE: begin
            if (occ_next < CNT_W'(DEPTH)) state_n = REQ;
         end
         REQ: begin
            if (imem_gnt) begin
               req_pc_n = pc;
               pc_n     = pc + XLEN'(4);
               state_n  = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (drop) begin
                  drop_n  = 1'b0;
                  state_n = REQ;
               end else begin
                  state_n = (occ_next < CNT_W'(DEPTH)) ? REQ : IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (redirect) begin
         pc_n = redirect_pc & ~XLEN'(3);
         // A response is still owed by memory: wait for it and throw it away
         if (((state == WAIT) && !imem_rvalid) || ((state == REQ) && imem_gnt)) begin
            drop_n  = 1'b1;
            state_n = WAIT;
         end else begin
            drop_n  = 1'b0;
            state_n = REQ;
         end
      end
   end

   // State, PC and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_pc   <= '0;
         drop     <= 1'b0;
         count    <= '0;
         imem_req <= 1'b0;
         id_valid <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         req_pc   <= req_pc_n;
         drop     <= drop_n;
         count    <= count_n;
         imem_req <= (state_n == REQ);
         id_valid <= (count_n != '0);
      end
   end

   // Shift queue: head is always the oldest entry, no bypass from rdata
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
      end else if (!redirect) begin
         if (pop) begin
            head <= (push && (count == CNT_W'(1))) ? resp : tail;
            if (push && (count == CNT_W'(2))) tail <= resp;
         end else if (push) begin
            if (count == '0) head <= resp;
            else             tail <= resp;
         end
      end
   end

endmodule
